if_ent_sched: RTL and testbench

- Shares one compare-select arithmetic datapath (the IfEnt function, made sequential) between two requesters.
- Round-robin arbitration between the requesters.
- Operands are accepted over valid/ready. One result at a time is held in an output register until the consumer takes it.
- The equal-operand path uses an iterative restoring divider, so latency depends on the data.

---
 rtl/if_ent_sched.sv | 130 +++++++++++++
 tb/tb_if_ent_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_ent_sched.sv
// Two-requester round-robin front end sharing one IfEnt compare-select datapath; result held until taken.
// Latency: result valid 2 cycles after the accept cycle, 2+NBITS when A==B!=0 (restoring divide).
// Backpressure: a result waits in DONE until out_ready; no new accept is taken until it is consumed.
module if_ent_sched #(
    parameter int NBITS = 8,
    parameter int KWARG = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [NBITS-1:0] req0_a,
    input  logic [NBITS-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [NBITS-1:0] req1_a,
    input  logic [NBITS-1:0] req1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_data,
    output logic             out_id,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

    localparam int              CW  = $clog2(NBITS + 1);
    localparam logic [NBITS-1:0] K   = NBITS'(KWARG);
    localparam logic [NBITS-1:0] ONE = NBITS'(1);

    state_t           state;
    logic             ptr;
    logic             id_q;
    logic [NBITS-1:0] a_q;
    logic [NBITS-1:0] b_q;
    logic [NBITS-1:0] rem_q;
    logic [NBITS-1:0] quo_q;
    logic [CW-1:0]    cnt_q;

    logic             grant;
    logic             acc0;
    logic             acc1;
    logic [NBITS-1:0] sq;
    logic [NBITS-1:0] simple_res;
    logic [NBITS:0]   trial;
    logic             fits;
    logic [NBITS-1:0] rem_nxt;
    logic [NBITS-1:0] quo_nxt;

    // ptr=1 means requester 1 wins a tie
    assign grant      = req1_valid & (~req0_valid | ptr);
    assign req0_ready = (state == IDLE) & rst_n & ~grant;
    assign req1_ready = (state == IDLE) & rst_n & grant;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    assign sq = a_q * a_q;

    always_comb begin
        simple_res = ONE + K;
        if (a_q > b_q)
            simple_res = a_q - ONE + K;
        else if (a_q < b_q)
            simple_res = {a_q[NBITS-2:0], 1'b0} - b_q + K;
    end

    // Restoring divide: quo_q starts as the dividend and shifts quotient bits in from the right
    assign trial   = {rem_q, quo_q[NBITS-1]};
    assign fits    = (trial >= {1'b0, b_q});
    assign rem_nxt = fits ? (trial[NBITS-1:0] - b_q) : trial[NBITS-1:0];
    assign quo_nxt = {quo_q[NBITS-2:0], fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            id_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            out_data <= '0;
            out_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        a_q   <= acc1 ? req1_a : req0_a;
                        b_q   <= acc1 ? req1_b : req0_b;
                        id_q  <= acc1;
                        ptr   <= ~acc1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if ((a_q == b_q) && (a_q != '0)) begin
                        quo_q <= sq;
                        rem_q <= '0;
                        cnt_q <= CW'(NBITS);
                        state <= DIV;
                    end else begin
                        out_data <= simple_res;
                        out_id   <= id_q;
                        state    <= DONE;
                    end
                end
                DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        out_data <= quo_nxt + ONE + K;
                        out_id   <= id_q;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_ent_sched.sv
// Directed bench for if_ent_sched: result function, latency, arbitration, stall and async reset abort.
module tb_if_ent_sched;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_id;
    logic       busy;

    int passed = 0;
    int total  = 0;

    if_ent_sched #(.NBITS(8), .KWARG(17)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called at #1 after an edge with the DUT idle; consumer ready throughout.
    task automatic run_job(input int rq, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_d, input int exp_lat, input string tag);
        int cyc;
        if (rq == 0) begin
            req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        #1;
        check({tag, " ready_granted"}, (rq == 0) ? req0_ready : req1_ready, 1);
        check({tag, " ready_other"},   (rq == 0) ? req1_ready : req0_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " data"}, out_data, exp_d);
        check({tag, " id"}, out_id, rq);
        @(posedge clk); #1;
        check({tag, " valid_drop"}, out_valid, 0);
    endtask

    initial begin
        int exp_g;
        int n;
        logic seen;

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd0; req0_b = 8'd0;
        req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_id", out_id, 0);
        check("rst busy", busy, 0);
        check("rst req0_ready", req0_ready, 0);
        req0_valid = 1'b0;
        rst_n = 1'b1;

        // Result function and latency
        run_job(0, 8'd10,  8'd3,   8'd26, 2,  "gt");
        run_job(1, 8'd3,   8'd10,  8'd13, 2,  "lt_wrap");
        run_job(0, 8'd255, 8'd0,   8'd15, 2,  "gt_max");
        run_job(0, 8'd20,  8'd20,  8'd25, 10, "eq20");
        run_job(1, 8'd16,  8'd16,  8'd18, 10, "eq16_wrap");
        run_job(0, 8'd0,   8'd0,   8'd18, 2,  "eq0");

        // Both requesters held valid from reset: strict alternation starting at 0
        rst_n = 1'b0;
        req0_a = 8'd5; req0_b = 8'd1; req1_a = 8'd5; req1_b = 8'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        exp_g = 0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            check("rr never_both", req0_ready & req1_ready, 0);
            if (req0_ready || req1_ready) begin
                check("rr grant", req1_ready, exp_g);
                exp_g ^= 1;
                n++;
            end
            if (out_valid) check("rr out_data", out_data, 21);
            @(posedge clk); #1;
        end
        check("rr grant_count", n, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("rr drain", busy, 0);

        // Stall in DONE
        out_ready = 1'b0;
        req0_a = 8'd10; req0_b = 8'd3; req0_valid = 1'b1;
        #1;
        check("stall accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        req1_a = 8'd3; req1_b = 8'd10; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("stall out_valid", out_valid, 1);
            check("stall out_data", out_data, 26);
            check("stall out_id", out_id, 0);
            check("stall req0_ready", req0_ready, 0);
            check("stall req1_ready", req1_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release valid_drop", out_valid, 0);
        check("release req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        check("release busy", busy, 1);
        check("release data_held", out_data, 26);
        @(posedge clk); #1;
        check("release out_valid", out_valid, 1);
        check("release out_data", out_data, 13);
        check("release out_id", out_id, 1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a divide
        req0_a = 8'd20; req0_b = 8'd20; req0_valid = 1'b1;
        #1;
        check("abort accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort busy_before", busy, 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort busy", busy, 0);
        check("abort out_data", out_data, 0);
        check("abort req0_ready", req0_ready, 0);
        check("abort req1_ready", req1_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort no_output", seen, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("abort favour0 req0", req0_ready, 1);
        check("abort favour0 req1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
